// File: rtl/trigger_pkg.sv
// Shared widths and the event record for the trigger event buffer.
package trigger_pkg;

    localparam int TRIG_ID_W  = 16;
    localparam int TRIG_TS_W  = 32;
    localparam int TRIG_SEQ_W = 8;

    typedef struct packed {
        logic [TRIG_ID_W-1:0]  id;
        logic [TRIG_TS_W-1:0]  ts;
        logic [TRIG_SEQ_W-1:0] seq;
    } trig_event_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with first-word-fall-through output.
// A push while full is still accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra MSB so equal low bits can mean full or empty.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign level   = level_q;
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + PTR_ONE;
            2'b01:   level_d = level_q - PTR_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/trigger_event_buffer.sv
// Captures decoded trigger IDs with timestamp and sequence tags into a FIFO.
// Define TRIG_TIMESTAMP_EN to keep the timestamp counter and storage; otherwise out_ts is 0.
module trigger_event_buffer
    import trigger_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int TS_W   = TRIG_TS_W,
    parameter int SEQ_W  = TRIG_SEQ_W,
    parameter int DROP_W = 16
) (
    input  logic                     sampling_clk,
    input  logic                     rst,
    input  logic                     interrupt,
    input  logic [TRIG_ID_W-1:0]     trigger_id,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TRIG_ID_W-1:0]     out_id,
    output logic [TS_W-1:0]          out_ts,
    output logic [SEQ_W-1:0]         out_seq,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_count,
    input  logic                     clr_status
);

    localparam logic [SEQ_W-1:0]  SEQ_ONE  = {{(SEQ_W-1){1'b0}}, 1'b1};
    localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop_fire;
    logic              drop;

`ifdef TRIG_TIMESTAMP_EN
    localparam int FIFO_W = $bits(trig_event_t);
    localparam logic [TS_W-1:0] TS_ONE = {{(TS_W-1){1'b0}}, 1'b1};

    logic [TS_W-1:0] ts_q;
    trig_event_t     wr_ev;
    trig_event_t     rd_ev;

    always_ff @(posedge sampling_clk) begin
        if (rst) ts_q <= '0;
        else     ts_q <= ts_q + TS_ONE;
    end

    always_comb begin
        wr_ev     = '0;
        wr_ev.id  = trigger_id;
        wr_ev.ts  = ts_q;
        wr_ev.seq = seq_q;
    end

    assign out_id  = rd_ev.id;
    assign out_ts  = rd_ev.ts;
    assign out_seq = rd_ev.seq;
`else
    // Timestamp field is dropped from the stored record entirely.
    localparam int FIFO_W = $bits(trig_event_t) - TRIG_TS_W;

    logic [FIFO_W-1:0] wr_ev;
    logic [FIFO_W-1:0] rd_ev;

    assign wr_ev   = {trigger_id, seq_q};
    assign out_id  = rd_ev[FIFO_W-1 -: TRIG_ID_W];
    assign out_ts  = '0;
    assign out_seq = rd_ev[SEQ_W-1:0];
`endif

    sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (sampling_clk),
        .rst   (rst),
        .push  (interrupt),
        .pop   (out_ready),
        .wdata (wr_ev),
        .rdata (rd_ev),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign out_valid = ~fifo_empty;
    assign pop_fire  = out_valid & out_ready;
    assign drop      = interrupt & fifo_full & ~pop_fire;

    always_comb begin
        seq_d      = seq_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (interrupt) seq_d = seq_q + SEQ_ONE;
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_q != '1) drop_d = drop_q + DROP_ONE;
        end
        // A clear in the same cycle as a drop wins; the seq gap still shows it.
        if (clr_status) begin
            overflow_d = 1'b0;
            drop_d     = '0;
        end
    end

    always_ff @(posedge sampling_clk) begin
        if (rst) begin
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: doc/trigger_event_buffer.md
Name: trigger_event_buffer

Overview:
Sits directly downstream of the trigger decoder. Each one-cycle interrupt pulse marks a completed 16-bit trigger ID; this block captures that ID, tags it with a timestamp and sequence number, and holds the event in a FIFO. The readout logic drains events over a valid/ready stream. Dropped events are counted, never silently lost.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
TS_W, 32, timestamp counter width.
SEQ_W, 8, sequence number width.
DROP_W, 16, drop counter width.

Ports:
sampling_clk  in  1  sole clock, same domain as the trigger decoder.
rst  in  1  synchronous, active-high reset.
interrupt  in  1  one-cycle pulse; trigger_id is valid in the same cycle.
trigger_id  in  16  decoded trigger ID.
out_valid  out  1  head event available.
out_ready  in  1  consumer accepts the head event when high together with out_valid.
out_id  out  16  head event trigger ID.
out_ts  out  TS_W  head event timestamp.
out_seq  out  SEQ_W  head event sequence number.
level  out  $clog2(DEPTH)+1  current occupancy.
overflow  out  1  sticky flag, set on any drop.
drop_count  out  DROP_W  saturating count of dropped events.
clr_status  in  1  clears overflow and drop_count.

Behaviour:
- Reset (rst=1 at a sampling_clk edge): out_valid=0, level=0, overflow=0, drop_count=0, timestamp counter=0, sequence counter=0. out_id, out_ts and out_seq read 0 while empty. rst overrides all other inputs, including mid-burst, and discards FIFO contents.
- Timestamp: free-running counter, +1 every cycle, wraps from 2^TS_W-1 to 0. An event records the counter value in the cycle interrupt is high.
- Sequence: increments once per interrupt pulse, whether the event is accepted or dropped, and wraps modulo 2^SEQ_W. A stored event carries the pre-increment value. The first event after reset has out_seq=0. Gaps in out_seq expose drops to the host.
- Push: an interrupt with the FIFO not full writes {trigger_id, ts, seq}.
- Full with a pop in the same cycle (out_valid & out_ready): the push is accepted and level stays at DEPTH.
- Full with no pop: the event is dropped, overflow is set to 1, and drop_count increments, saturating at all-ones.
- Output is first-word-fall-through. A push into an empty FIFO gives out_valid=1 on the next cycle. Input-to-output latency is 1 cycle.
- Pop: out_valid & out_ready advances the head. out_ready while empty has no effect.
- Output fields are held stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop when not empty and not full: level is unchanged.
- level updates in the same cycle as the pointers: +1 on push only, -1 on pop only.
- Read/write pointers are $clog2(DEPTH)+1 bits. The extra MSB distinguishes full from empty.
- clr_status in the same cycle as a drop: clear wins, so overflow=0 and drop_count=0. The drop is still recorded by the sequence gap.
- Status outputs are registered, 1 cycle after the event.

Optional Feature:
TRIG_TIMESTAMP_EN.
- Defined: timestamp counter and storage are present, as described in Behaviour.
- Undefined: counter and timestamp storage are removed. out_ts is tied to 0 and keeps its TS_W width so port lists do not change. All other behaviour is identical.

Decomposition:
- Package trigger_pkg:
  - TRIG_ID_W=16.
  - Default TS_W and SEQ_W.
  - Typedef trig_event_t, a packed struct {id, ts, seq}.
- Sub-module sync_fifo: generic width/depth FIFO with first-word-fall-through output, full/empty/level outputs, synchronous rst. trigger_event_buffer instantiates it with width = $bits(trig_event_t).
- Counters, drop logic and status stay in the top module.

Test Plan:
- Reset release, then interrupt with trigger_id=16'hA5C3 at timestamp 10 -> next cycle out_valid=1, out_id=A5C3, out_ts=10, out_seq=0, level=1.
- 16 pulses, out_ready=0, IDs 0..15 -> level=16, overflow=0. A 17th pulse -> overflow=1, drop_count=1, level=16. Drain -> IDs 0..15 in order, out_seq 0..15. The next accepted event has out_seq=17.
- FIFO full, interrupt and pop in the same cycle -> no drop, level stays 16, the new event appears last in drain order.
- Back-to-back pulses with out_ready=1 every cycle -> out_valid continuous, no drops, level never exceeds 2.
- clr_status coincident with a drop at full -> overflow=0 and drop_count=0 next cycle. Sequence gap of 1 observed on drain.
- rst asserted with level=5 -> the cycle after the rst edge out_valid=0 and level=0. The next event has out_seq=0 and out_ts equal to cycles since reset. With TRIG_TIMESTAMP_EN undefined, out_ts=0 throughout.
